uart_rx: RTL and testbench

UART receiver: the receive-side counterpart of the SoC's `uart_tx`. It recovers 8N1 frames (1 start, 8 data LSB first, 1 stop) from the asynchronous `rx` pin by mid-bit sampling. Each byte is presented to the core-side MMIO/UART wrapper as a one-cycle valid pulse, and bad stop bits are flagged. It shares `CLKS_PER_BIT` semantics with `uart_tx`, so one parameter value serves both directions.

---
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver using mid-bit sampling.
// It recovers one byte per frame from the asynchronous rx pin. Each good byte
// is reported with a one-cycle rx_valid pulse. A low stop bit is reported with
// a one-cycle rx_frame_err pulse instead.
// CLKS_PER_BIT has the same meaning as in uart_tx.

module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START_BIT = 3'd1;
  localparam logic [2:0] DATA_BITS = 3'd2;
  localparam logic [2:0] STOP_BIT  = 3'd3;
  localparam logic [2:0] CLEANUP   = 3'd4;

  localparam logic [31:0] HALF = 32'((CLKS_PER_BIT - 1) / 2);
  localparam logic [31:0] LAST = 32'(CLKS_PER_BIT - 1);

  logic        rx_meta_q, rx_meta_d;
  logic        rx_s_q, rx_s_d;
  logic [1:0]  sync_vld_q, sync_vld_d;
  logic        arm_q, arm_d;
  logic [2:0]  state_q, state_d;
  logic [31:0] clk_count_q, clk_count_d;
  logic [2:0]  bit_index_q, bit_index_d;
  logic [7:0]  buffer_q, buffer_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_frame_err_q, rx_frame_err_d;

  // Next-state logic: synchronizer, arm flag, and the receive FSM.
  // sync_vld marks when rx_s holds a real sample of the pin rather than its
  // reset value of 1. The arm flag only trusts real samples, so a line held
  // low through reset can never start a frame.
  always_comb begin
    rx_meta_d      = rx;
    rx_s_d         = rx_meta_q;
    sync_vld_d     = {sync_vld_q[0], 1'b1};
    arm_d          = arm_q | (sync_vld_q[1] & rx_s_q);
    state_d        = state_q;
    clk_count_d    = clk_count_q;
    bit_index_d    = bit_index_q;
    buffer_d       = buffer_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        clk_count_d = 32'd0;
        bit_index_d = 3'd0;
        if (arm_q && !rx_s_q) begin
          state_d = START_BIT;
        end
      end

      START_BIT: begin
        if (clk_count_q == HALF) begin
          clk_count_d = 32'd0;
          // A line that is high again at mid-start was only a glitch.
          state_d = rx_s_q ? IDLE : DATA_BITS;
        end else begin
          clk_count_d = clk_count_q + 32'd1;
        end
      end

      DATA_BITS: begin
        if (clk_count_q == LAST) begin
          clk_count_d           = 32'd0;
          buffer_d[bit_index_q] = rx_s_q;
          if (bit_index_q == 3'd7) begin
            bit_index_d = 3'd0;
            state_d     = STOP_BIT;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end else begin
          clk_count_d = clk_count_q + 32'd1;
        end
      end

      STOP_BIT: begin
        if (clk_count_q == LAST) begin
          clk_count_d = 32'd0;
          if (rx_s_q) begin
            rx_data_d  = buffer_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_frame_err_d = 1'b1;
          end
          state_d = CLEANUP;
        end else begin
          clk_count_d = clk_count_q + 32'd1;
        end
      end

      CLEANUP: begin
        // Wait for the line to return high.
        // This stops a break or framing error from retriggering a start.
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        clk_count_d = 32'd0;
        bit_index_d = 3'd0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q      <= 1'b1;
      rx_s_q         <= 1'b1;
      sync_vld_q     <= 2'b00;
      arm_q          <= 1'b0;
      state_q        <= IDLE;
      clk_count_q    <= 32'd0;
      bit_index_q    <= 3'd0;
      buffer_q       <= 8'h00;
      rx_data_q      <= 8'h00;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rx_meta_q      <= rx_meta_d;
      rx_s_q         <= rx_s_d;
      sync_vld_q     <= sync_vld_d;
      arm_q          <= arm_d;
      state_q        <= state_d;
      clk_count_q    <= clk_count_d;
      bit_index_q    <= bit_index_d;
      buffer_q       <= buffer_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenario bench for uart_rx at CLKS_PER_BIT=16.
// A serializer task drives 8N1 frames onto rx.
// A monitor logs every pulse with the cycle in which it was seen.

module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int         valid_count   = 0;
  int         err_count     = 0;
  int         overlap_count = 0;
  int         last_err_cyc  = -1;
  int         busy_rise     = -1;
  int         busy_fall     = -1;
  logic       busy_prev     = 1'b0;
  logic [7:0] vdata [0:511];
  int         vcyc  [0:511];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter: cyc is the index of the interval following each posedge.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples outputs on the falling edge and logs pulses and busy edges.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      if (valid_count < 512) begin
        vdata[valid_count] = rx_data;
        vcyc[valid_count]  = cyc;
      end
      valid_count++;
    end
    if (rx_frame_err === 1'b1) begin
      err_count++;
      last_err_cyc = cyc;
    end
    if (rx_valid === 1'b1 && rx_frame_err === 1'b1) overlap_count++;
    if (rx_busy === 1'b1 && busy_prev === 1'b0) busy_rise = cyc;
    if (rx_busy === 1'b0 && busy_prev === 1'b1) busy_fall = cyc;
    busy_prev = (rx_busy === 1'b1);
  end

  // Drives one frame. c0 is the cycle in which the start bit was driven.
  // rx is left at the stop level when the task returns.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int c0);
    c0 = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err: got %b expected 0", rx_frame_err); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", rx_busy); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_busy: got %b expected 0", rx_busy); end
  endtask

  task automatic test_clean_frame();
    int v0, e0, c0;
    v0 = valid_count; e0 = err_count;
    send_frame(8'hA5, 1'b1, c0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    checks++; if (valid_count - v0 !== 1) begin failures++; $display("[TB] FAIL clean_valid_count: got %0d expected 1", valid_count - v0); end
    checks++; if (vdata[v0] !== 8'hA5) begin failures++; $display("[TB] FAIL clean_data: got %h expected a5", vdata[v0]); end
    checks++; if (vcyc[v0] !== c0 + 155) begin failures++; $display("[TB] FAIL clean_valid_cycle: got %0d expected %0d", vcyc[v0], c0 + 155); end
    checks++; if (busy_rise !== c0 + 3) begin failures++; $display("[TB] FAIL clean_busy_rise: got %0d expected %0d", busy_rise, c0 + 3); end
    checks++; if (busy_fall !== c0 + 156) begin failures++; $display("[TB] FAIL clean_busy_fall: got %0d expected %0d", busy_fall, c0 + 156); end
    checks++; if (err_count !== e0) begin failures++; $display("[TB] FAIL clean_no_err: got %0d expected %0d", err_count, e0); end
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("[TB] FAIL clean_data_hold: got %h expected a5", rx_data); end
  endtask

  task automatic test_glitch();
    int v0, e0, c0;
    v0 = valid_count; e0 = err_count;
    c0 = cyc;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    checks++; if (busy_rise !== c0 + 3) begin failures++; $display("[TB] FAIL glitch_busy_rise: got %0d expected %0d", busy_rise, c0 + 3); end
    checks++; if (busy_fall !== c0 + 11) begin failures++; $display("[TB] FAIL glitch_idle_cycle: got %0d expected %0d", busy_fall, c0 + 11); end
    checks++; if (valid_count !== v0) begin failures++; $display("[TB] FAIL glitch_no_valid: got %0d expected %0d", valid_count, v0); end
    checks++; if (err_count !== e0) begin failures++; $display("[TB] FAIL glitch_no_err: got %0d expected %0d", err_count, e0); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL glitch_busy: got %b expected 0", rx_busy); end
  endtask

  task automatic test_frame_error();
    int v0, e0, c0;
    v0 = valid_count; e0 = err_count;
    send_frame(8'h3C, 1'b0, c0);
    repeat (40) @(negedge clk);
    #1;
    checks++; if (rx_busy !== 1'b1) begin failures++; $display("[TB] FAIL ferr_cleanup_busy: got %b expected 1", rx_busy); end
    checks++; if (err_count - e0 !== 1) begin failures++; $display("[TB] FAIL ferr_count: got %0d expected 1", err_count - e0); end
    checks++; if (last_err_cyc !== c0 + 155) begin failures++; $display("[TB] FAIL ferr_cycle: got %0d expected %0d", last_err_cyc, c0 + 155); end
    checks++; if (valid_count !== v0) begin failures++; $display("[TB] FAIL ferr_no_valid: got %0d expected %0d", valid_count, v0); end
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("[TB] FAIL ferr_data_kept: got %h expected a5", rx_data); end
    rx = 1'b1;
    repeat (200) @(negedge clk);
    #1;
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL ferr_back_idle: got %b expected 0", rx_busy); end
    checks++; if (err_count - e0 !== 1 || valid_count !== v0) begin failures++; $display("[TB] FAIL ferr_no_spurious: got err=%0d valid=%0d expected err=1 valid=0", err_count - e0, valid_count - v0); end
  endtask

  task automatic test_back_to_back();
    int v0, e0, c0, c1, c2;
    logic [7:0] exp_b [0:2];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
    v0 = valid_count; e0 = err_count;
    send_frame(8'h00, 1'b1, c0);
    send_frame(8'hFF, 1'b1, c1);
    send_frame(8'h55, 1'b1, c2);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    checks++; if (valid_count - v0 !== 3) begin failures++; $display("[TB] FAIL b2b_count: got %0d expected 3", valid_count - v0); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (vdata[v0 + k] !== exp_b[k]) begin failures++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", k, vdata[v0 + k], exp_b[k]); end
    end
    checks++; if (vcyc[v0] !== c0 + 155) begin failures++; $display("[TB] FAIL b2b_first_cycle: got %0d expected %0d", vcyc[v0], c0 + 155); end
    checks++; if (vcyc[v0 + 1] - vcyc[v0] !== 160) begin failures++; $display("[TB] FAIL b2b_spacing01: got %0d expected 160", vcyc[v0 + 1] - vcyc[v0]); end
    checks++; if (vcyc[v0 + 2] - vcyc[v0 + 1] !== 160) begin failures++; $display("[TB] FAIL b2b_spacing12: got %0d expected 160", vcyc[v0 + 2] - vcyc[v0 + 1]); end
    checks++; if (err_count !== e0) begin failures++; $display("[TB] FAIL b2b_no_err: got %0d expected %0d", err_count, e0); end
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0, r0, c0;
    checks++; if (rx_data !== 8'h55) begin failures++; $display("[TB] FAIL midrst_pre_data: got %h expected 55", rx_data); end
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL midrst_data: got %h expected 00", rx_data); end
    checks++; if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin failures++; $display("[TB] FAIL midrst_outputs: got busy=%b valid=%b err=%b expected 0 0 0", rx_busy, rx_valid, rx_frame_err); end
    rst = 1'b0;
    #1;
    v0 = valid_count; e0 = err_count; r0 = busy_rise;
    repeat (60) @(negedge clk);
    #1;
    checks++; if (busy_rise !== r0 || rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_low_line_ignored: got rise=%0d busy=%b expected rise=%0d busy=0", busy_rise, rx_busy, r0); end
    checks++; if (valid_count !== v0 || err_count !== e0) begin failures++; $display("[TB] FAIL midrst_no_pulses: got valid=%0d err=%0d expected 0 0", valid_count - v0, err_count - e0); end
    rx = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h81, 1'b1, c0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    checks++; if (valid_count - v0 !== 1) begin failures++; $display("[TB] FAIL midrst_fresh_count: got %0d expected 1", valid_count - v0); end
    checks++; if (vdata[v0] !== 8'h81) begin failures++; $display("[TB] FAIL midrst_fresh_data: got %h expected 81", vdata[v0]); end
    checks++; if (vcyc[v0] !== c0 + 155) begin failures++; $display("[TB] FAIL midrst_fresh_cycle: got %0d expected %0d", vcyc[v0], c0 + 155); end
  endtask

  task automatic test_loopback();
    int v0, e0, c0;
    v0 = valid_count; e0 = err_count;
    for (int v = 0; v < 256; v++) begin
      send_frame(8'(v), 1'b1, c0);
    end
    rx = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    checks++; if (valid_count - v0 !== 256) begin failures++; $display("[TB] FAIL loop_count: got %0d expected 256", valid_count - v0); end
    for (int v = 0; v < 256; v++) begin
      checks++; if (vdata[v0 + v] !== 8'(v)) begin failures++; $display("[TB] FAIL loop_byte%0d: got %h expected %h", v, vdata[v0 + v], 8'(v)); end
    end
    checks++; if (err_count !== e0) begin failures++; $display("[TB] FAIL loop_no_err: got %0d expected %0d", err_count, e0); end
    checks++; if (overlap_count !== 0) begin failures++; $display("[TB] FAIL valid_err_exclusive: got %0d expected 0", overlap_count); end
  endtask

  // Scenario sequence.
  initial begin
    @(negedge clk);
    test_reset();
    test_clean_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
